// File: rtl/rom_loader.sv
// Download-port to SDRAM write-stream bridge: toggle strobe in, queued req/ack out,
// end-of-load size/mask report. Define ROM_LOADER_HDR_STRIP_EN to strip a 512-byte copier header.
module rom_loader #(
  parameter logic [7:0] ROM_INDEX  = 8'h00,
  parameter int         FIFO_DEPTH = 4,
  parameter int         ADDR_W     = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  input  logic [23:0]       ioctl_filesize,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] rom_size,
  output logic [ADDR_W-1:0] rom_mask
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
  state_t state, state_n;

  logic              wr_q, armed, evt;
  logic              stg_vld;
  logic [24:0]       stg_addr;
  logic [15:0]       stg_data;
  logic              hdr;
  logic [PW:0]       wp, rp;
  logic [ADDR_W+15:0] fifo_mem [FIFO_DEPTH];
  logic              empty, full, pop, push, push_try, hdr_drop, range_bad, go;
  logic [24:0]       eff;
  logic [ADDR_W:0]   eff_end, max_end, end_m1;
  logic              unused_ok;

  // armed masks the first cycle after reset, before wr_q has seen the real strobe level
  assign evt       = armed && (ioctl_wr ^ wr_q);
  assign go        = (state == S_IDLE) && ioctl_download && (ioctl_index == ROM_INDEX);
  assign empty     = (wp == rp);
  assign full      = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign pop       = mem_ack && !empty;
  assign eff       = stg_addr - (hdr ? 25'd512 : 25'd0);
  assign hdr_drop  = hdr && (stg_addr < 25'd512);
  assign range_bad = ({1'b0, eff} >= (26'd1 << ADDR_W));
  assign push_try  = stg_vld && !hdr_drop && !range_bad;
  assign push      = push_try && (!full || pop);
  assign eff_end   = {1'b0, eff[ADDR_W-1:0]} + (ADDR_W+1)'(2);
  assign end_m1    = max_end - (ADDR_W+1)'(1);

  assign mem_req  = !empty;
  assign mem_addr = empty ? '0 : fifo_mem[rp[PW-1:0]][ADDR_W+15:16];
  assign mem_din  = empty ? '0 : fifo_mem[rp[PW-1:0]][15:0];

  assign unused_ok = ^{ioctl_filesize, end_m1[ADDR_W]};

  function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = v;
    for (int s = 1; s < ADDR_W; s = s << 1) r = r | (r >> s);
    return r;
  endfunction

`ifdef ROM_LOADER_HDR_STRIP_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)   hdr <= 1'b0;
    else if (go) hdr <= (ioctl_filesize[9:0] == 10'h200);
  end
`else
  assign hdr = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (go) state_n = S_LOAD;
      S_LOAD:  if (!ioctl_download) state_n = S_DRAIN;
      S_DRAIN: if (empty && !stg_vld) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      armed     <= 1'b0;
      stg_vld   <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      wp        <= '0;
      rp        <= '0;
      max_end   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      rom_size  <= '0;
      rom_mask  <= '0;
    end else begin
      state     <= state_n;
      wr_q      <= ioctl_wr;
      armed     <= 1'b1;
      // capture stage: the push lands one edge after the toggle is sampled
      stg_vld   <= evt && (state == S_LOAD);
      stg_addr  <= ioctl_addr;
      stg_data  <= ioctl_dout;
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (go)
        max_end <= '0;
      else if (push && (eff_end > max_end))
        max_end <= eff_end;
      if (go)
        overflow <= 1'b0;
      else if ((evt && state != S_LOAD) || (stg_vld && !hdr_drop && (range_bad || !push)))
        overflow <= 1'b1;
      busy      <= (state_n == S_LOAD) || (state_n == S_DRAIN);
      load_done <= (state == S_DONE);
      if (state == S_DONE) begin
        rom_size <= max_end[ADDR_W-1:0];
        rom_mask <= (max_end == '0) ? '0 : smear(end_m1[ADDR_W-1:0]);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wp[PW-1:0]] <= {eff[ADDR_W-1:0], stg_data};
  end
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: basic load, header file, sizes, backpressure, index filter, reset.
module tb_rom_loader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [23:0] ioctl_filesize = '0;
  logic        mem_req, mem_ack = 1'b0;
  logic [23:0] mem_addr, rom_size, rom_mask;
  logic [15:0] mem_din;
  logic        busy, load_done, overflow;

  rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_filesize(ioctl_filesize), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack), .busy(busy),
    .load_done(load_done), .overflow(overflow), .rom_size(rom_size), .rom_mask(rom_mask)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, errors = 0;
  int done_cnt = 0;
  bit ack_en = 1'b0, req_seen = 1'b0, busy_seen = 1'b0;
  logic [23:0] wa_q[$];
  logic [15:0] wd_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave model: ack one cycle after a request is seen, logging what is accepted
  always @(negedge clk_sys) begin
    if (load_done) done_cnt++;
    if (mem_req) req_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (ack_en && mem_req && !mem_ack && !reset) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
      mem_ack = 1'b1;
    end else
      mem_ack = 1'b0;
  end

  task automatic start(input logic [7:0] idx, input logic [23:0] size);
    @(negedge clk_sys);
    wa_q.delete(); wd_q.delete();
    ioctl_index = idx; ioctl_filesize = size; ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic send(input logic [24:0] a, input logic [15:0] d, input int gap);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = ~ioctl_wr;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic end_load(input string tag);
    int d0, n;
    d0 = done_cnt; n = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    while (done_cnt == d0 && n < 300) begin @(negedge clk_sys); n++; end
    repeat (4) @(negedge clk_sys);
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [23:0] a, input logic [15:0] d);
    chk({tag, "_addr"}, (i < wa_q.size()) ? wa_q[i] : 24'hxxxxxx, a);
    chk({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 16'hxxxx, d);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk_sys);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_size", rom_size, 0);
    chk("rst_mask", rom_mask, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // basic 4-word load
    ack_en = 1'b1;
    start(8'h00, 24'h000008);
    chk("basic_busy", busy, 1);
    send(25'h0, 16'h1111, 3); send(25'h2, 16'h2222, 3);
    send(25'h4, 16'h3333, 3); send(25'h6, 16'h4444, 3);
    end_load("basic");
    chk("basic_cnt", wa_q.size(), 4);
    chk_wr("basic0", 0, 24'h0, 16'h1111);
    chk_wr("basic1", 1, 24'h2, 16'h2222);
    chk_wr("basic2", 2, 24'h4, 16'h3333);
    chk_wr("basic3", 3, 24'h6, 16'h4444);
    chk("basic_size", rom_size, 24'h8);
    chk("basic_mask", rom_mask, 24'h7);
    chk("basic_ovf", overflow, 0);
    chk("basic_busy_end", busy, 0);

    // copier-header sized file
    start(8'h00, 24'h008200);
    send(25'h000, 16'hA000, 3); send(25'h1FE, 16'hA1FE, 3);
    send(25'h200, 16'hA200, 3); send(25'h81FE, 16'hA81E, 3);
    end_load("hdr");
`ifdef ROM_LOADER_HDR_STRIP_EN
    chk("hdr_cnt", wa_q.size(), 2);
    chk_wr("hdr0", 0, 24'h0000, 16'hA200);
    chk_wr("hdr1", 1, 24'h7FFE, 16'hA81E);
    chk("hdr_size", rom_size, 24'h8000);
    chk("hdr_mask", rom_mask, 24'h7FFF);
`else
    chk("hdr_cnt", wa_q.size(), 4);
    chk_wr("hdr0", 0, 24'h0000, 16'hA000);
    chk_wr("hdr2", 2, 24'h0200, 16'hA200);
    chk("hdr_size", rom_size, 24'h8200);
    chk("hdr_mask", rom_mask, 24'hFFFF);
`endif

    // non-power-of-two size, sparse words
    start(8'h00, 24'h030000);
    send(25'h0, 16'h0001, 3); send(25'h2FFFE, 16'hBEEF, 3);
    end_load("np2");
    chk_wr("np2_1", 1, 24'h2FFFE, 16'hBEEF);
    chk("np2_size", rom_size, 24'h030000);
    chk("np2_mask", rom_mask, 24'h03FFFF);
    chk("np2_ovf", overflow, 0);

    // index filter
    @(negedge clk_sys);
    req_seen = 1'b0; busy_seen = 1'b0;
    start(8'h01, 24'h000006);
    send(25'h0, 16'h1, 2); send(25'h2, 16'h2, 2); send(25'h4, 16'h3, 2);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("idx_req", req_seen, 0);
    chk("idx_busy", busy_seen, 0);
    chk("idx_ovf", overflow, 1);

    // backpressure: 5 words into a 4-deep FIFO
    ack_en = 1'b0;
    start(8'h00, 24'h000020);
    chk("bp_ovf_clr", overflow, 0);
    send(25'h10, 16'hC000, 2); send(25'h12, 16'hC001, 2); send(25'h14, 16'hC002, 2);
    send(25'h16, 16'hC003, 2); send(25'h18, 16'hC004, 3);
    chk("bp_ovf", overflow, 1);
    chk("bp_req", mem_req, 1);
    chk("bp_head", mem_addr, 24'h10);
    @(negedge clk_sys);
    chk("bp_hold", mem_din, 16'hC000);
    ack_en = 1'b1;
    end_load("bp");
    chk("bp_cnt", wa_q.size(), 4);
    chk_wr("bp3", 3, 24'h16, 16'hC003);
    chk("bp_size", rom_size, 24'h18);

    // async reset with two words queued
    ack_en = 1'b0;
    start(8'h00, 24'h000004);
    send(25'h20, 16'hAAAA, 2); send(25'h22, 16'hBBBB, 3);
    chk("rl_req", mem_req, 1);
    d0 = done_cnt;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("rl_req0", mem_req, 0);
    chk("rl_addr0", mem_addr, 0);
    chk("rl_din0", mem_din, 0);
    chk("rl_size0", rom_size, 0);
    chk("rl_mask0", rom_mask, 0);
    chk("rl_busy0", busy, 0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (6) @(negedge clk_sys);
    chk("rl_nodone", done_cnt - d0, 0);
    chk("rl_ovf", overflow, 0);
    ack_en = 1'b1;
    start(8'h00, 24'h000002);
    send(25'h0, 16'h5A5A, 3);
    end_load("rl_new");
    chk("rl_new_cnt", wa_q.size(), 1);
    chk_wr("rl_new0", 0, 24'h0, 16'h5A5A);
    chk("rl_new_size", rom_size, 24'h2);
    chk("rl_new_mask", rom_mask, 24'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Downstream consumer of the ARM→FPGA download port. It turns toggle-style `ioctl_wr` word events into a queued request/acknowledge write stream for the SDRAM controller. It optionally strips a 512-byte copier header and, at the end of each download, reports the ROM size and the power-of-two address mask. It sits between the download SPI receiver and the SDRAM arbiter's loader port.

## Interface
Parameters:
- `ROM_INDEX`, default 8'h00. Only downloads with `ioctl_index` equal to this value are loaded.
- `FIFO_DEPTH`, default 4. Word FIFO depth; must be a power of two, ≥2.
- `ADDR_W`, default 24. Byte address width of `mem_addr`.

Ports (one clock; reset is asynchronous and active-high):
- `clk_sys`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `ioctl_download`  in  1  download active (level)
- `ioctl_index`  in  8  menu index of the current file
- `ioctl_wr`  in  1  word strobe; each edge (either polarity) is one word
- `ioctl_addr`  in  25  byte address of the word, always even
- `ioctl_dout`  in  16  word data, little-endian
- `ioctl_filesize`  in  24  file size in bytes; stable before `ioctl_download` rises
- `mem_req`  out  1  write request valid
- `mem_addr`  out  ADDR_W  byte address, bit 0 = 0
- `mem_din`  out  16  write data
- `mem_ack`  in  1  one-cycle pulse: the current request is accepted
- `busy`  out  1  high in LOAD and DRAIN
- `load_done`  out  1  one-cycle pulse when a load completes
- `overflow`  out  1  sticky error flag; cleared on entry to LOAD
- `rom_size`  out  ADDR_W  bytes written; header excluded
- `rom_mask`  out  ADDR_W  (next power of two ≥ rom_size) − 1

## Operation
- Edge detect: register `wr_q <= ioctl_wr`. Event = `ioctl_wr ^ wr_q`. `wr_q` is reloaded from `ioctl_wr` on LOAD entry, so no spurious first event occurs.
- States:
  - IDLE → LOAD when `ioctl_download` = 1 and `ioctl_index` = `ROM_INDEX`.
  - LOAD → DRAIN when `ioctl_download` = 0.
  - DRAIN → DONE when the FIFO is empty and `mem_req` = 0.
  - DONE → IDLE unconditionally after one cycle.
- On LOAD entry:
  - clear `overflow` and the max-address tracker;
  - latch `hdr = (ioctl_filesize[9:0] == 10'h200)` (with the header-strip feature only).
- Event in LOAD:
  - effective address = `ioctl_addr` − (hdr ? 512 : 0);
  - words with `ioctl_addr` < 512 while hdr is set are dropped silently;
  - a word whose effective address is ≥ 2^ADDR_W is dropped and sets `overflow`;
  - otherwise push {addr, data}. Pushing into a full FIFO drops the word and sets `overflow`, unless a pop happens in the same cycle, in which case the push is accepted.
- Events in any state other than LOAD are ignored and set `overflow`.
- Tracker: `max_end = max(max_end, eff_addr + 2)` on every accepted push.
- Output side: `mem_req` = FIFO non-empty; `mem_addr`/`mem_din` = FIFO head. `mem_ack` pops the head. `mem_ack` arriving while `mem_req` = 0 is ignored.
- DONE:
  - `rom_size <= max_end`;
  - `rom_mask <=` bit-smear OR of (`max_end` − 1); 0 when `max_end` = 0;
  - `load_done` = 1 for this cycle.
- Reset: FIFO emptied, state IDLE. All outputs go to 0: `mem_req`, `mem_addr`, `mem_din`, `busy`, `load_done`, `overflow`, `rom_size`, `rom_mask`. A reset mid-load abandons the load; no `load_done` is issued.

## Timing
- Toggle sampled at edge N → FIFO write at edge N+1 → `mem_req` = 1 after edge N+1. Two cycles from `ioctl_wr` change to request.
- `mem_req`, `mem_addr` and `mem_din` hold stable until `mem_ack`. After an ack with entries remaining, the next entry is presented the following cycle with `mem_req` kept high.
- Throughput: one word per cycle if `mem_ack` is permanently high.
- `ioctl_download` falling with the FIFO empty and `mem_req` = 0: DRAIN lasts one cycle, then DONE (`load_done` pulse) two cycles after the fall is sampled.
- `busy` is registered and equals (state ∈ {LOAD, DRAIN}).

## Configuration
- `ROM_LOADER_HDR_STRIP_EN` defined:
  - copier-header detection and the −512 address offset are built in;
  - a file of size 0x8200 yields `rom_size` = 0x8000.
- Not defined:
  - hdr is forced to 0 and all words pass with `mem_addr = ioctl_addr[ADDR_W-1:0]`;
  - a file of size 0x8200 yields `rom_size` = 0x8200 and `rom_mask` = 0xFFFF.

## Test plan
- Basic load: filesize 0x000008 (no header), 4 toggles with addresses 0, 2, 4, 6 and data 0x1111–0x4444, `mem_ack` one cycle after each request → 4 writes in order with matching address/data; `load_done` pulses once; `rom_size` = 8; `rom_mask` = 7.
- Header strip (`ROM_LOADER_HDR_STRIP_EN` defined): filesize 0x8200, words written at byte addresses 0x000–0x81FE → first 256 words dropped; word from 0x200 written to `mem_addr` 0; `rom_size` = 0x8000; `rom_mask` = 0x7FFF.
- Backpressure: `mem_ack` held low, 5 events with `FIFO_DEPTH` = 4 → 4 entries queued, 5th dropped, `overflow` = 1; on release of `mem_ack`, exactly 4 writes are issued.
- Non-power-of-two size: 0x30000 bytes loaded → `rom_size` = 0x30000; `rom_mask` = 0x3FFFF.
- Index filter: `ioctl_index` = 1 with `ROM_INDEX` = 0 and 3 toggles → `mem_req` never asserted, `busy` stays 0, `overflow` = 1.
- Async reset mid-load: assert `reset` with 2 words queued → `mem_req` = 0 immediately; no `load_done`; all outputs 0. A new download after reset loads normally.
